// File: rtl/mem_access_unit_pkg.sv
// Shared types and defaults for the data-memory access unit.
// AW/DW/ROW_D defaults match the data memory's row and column sizes.
package mem_access_unit_pkg;

   localparam int AW_DEF    = 16;
   localparam int DW_DEF    = 16;
   localparam int ROW_D_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_e;

   typedef struct packed {
      logic              we;
      logic [AW_DEF-1:0] addr;
      logic [DW_DEF-1:0] wdata;
   } req_entry_t;

   // Full-width unsigned compare, so high address bits never alias into range
   function automatic logic addr_in_range(input logic [AW_DEF-1:0] addr, input int rows);
      logic [31:0] a32;
      logic [31:0] r32;
      a32 = 32'(addr);
      r32 = rows;
      return (a32 < r32);
   endfunction

endpackage

// File: rtl/mem_access_unit_req_fifo.sv
// In-order request queue with synchronous reset; push is refused when full
// even if a pop happens in the same cycle.
module req_fifo #(
   parameter int  WIDTH = 33,
   parameter int  DEPTH = 2,
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign dout  = mem_q[rd_ptr_q];
   assign count = count_q;

   // Next pointer and occupancy; pointers wrap naturally since DEPTH is a power of two
   always_comb begin
      do_push  = push & !full;
      do_pop   = pop & !empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (!do_push && do_pop) count_d = count_q - CW'(1);
   end

   // Pointer and count registers, cleared by reset to an empty queue
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage needs no reset; only slots behind the count are ever read
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/mem_access_unit.sv
// Initiator side of the data-memory port: queues load/store requests, issues
// them one at a time and returns load data over a valid/ready channel.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int ROW_D = ROW_D_DEF,
   parameter int AW    = AW_DEF,
   parameter int DW    = DW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_rdata,
   output logic          rsp_err,
   output logic          st_err,
   output logic          busy,
   output logic [AW-1:0] mem_access_addr,
   output logic [DW-1:0] mem_write_data,
   output logic          mem_write_en,
   output logic          mem_read,
   input  logic [DW-1:0] mem_read_data
);

   localparam int CW = $clog2(DEPTH + 1);

   req_entry_t    fifo_din, fifo_dout;
   logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;
   logic          head_ok;

   state_e        state_q, state_d;
   logic          issue_we_q, issue_we_d;
   logic          issue_ok_q, issue_ok_d;
   logic [AW-1:0] mem_access_addr_q, mem_access_addr_d;
   logic [DW-1:0] mem_write_data_q, mem_write_data_d;
   logic          mem_write_en_q, mem_write_en_d;
   logic          mem_read_q, mem_read_d;
   logic          st_err_q, st_err_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
   logic          rsp_err_q, rsp_err_d;

   assign fifo_din  = '{we: req_we, addr: req_addr, wdata: req_wdata};
   assign fifo_push = req_valid & !fifo_full;
   assign head_ok   = addr_in_range(fifo_dout.addr, ROW_D);

   req_fifo #(
      .WIDTH($bits(req_entry_t)),
      .DEPTH(DEPTH)
   ) u_req_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (fifo_push),
      .pop  (fifo_pop),
      .din  (fifo_din),
      .dout (fifo_dout),
      .full (fifo_full),
      .empty(fifo_empty),
      .count(fifo_count)
   );

   // Sequencer: memory strobes are set up at pop time so they are registered
   // and high exactly during the ISSUE cycle; out-of-range addresses never
   // reach mem_access_addr
   always_comb begin
      state_d           = state_q;
      issue_we_d        = issue_we_q;
      issue_ok_d        = issue_ok_q;
      mem_access_addr_d = mem_access_addr_q;
      mem_write_data_d  = mem_write_data_q;
      mem_write_en_d    = mem_write_en_q;
      mem_read_d        = mem_read_q;
      st_err_d          = st_err_q;
      rsp_valid_d       = rsp_valid_q;
      rsp_rdata_d       = rsp_rdata_q;
      rsp_err_d         = rsp_err_q;
      fifo_pop          = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               issue_we_d = fifo_dout.we;
               issue_ok_d = head_ok;
               state_d    = ISSUE;
               if (head_ok) begin
                  mem_access_addr_d = fifo_dout.addr;
                  if (fifo_dout.we) begin
                     mem_write_en_d   = 1'b1;
                     mem_write_data_d = fifo_dout.wdata;
                  end else begin
                     mem_read_d = 1'b1;
                  end
               end else if (fifo_dout.we) begin
                  st_err_d = 1'b1;
               end
            end
         end
         ISSUE: begin
            mem_write_en_d = 1'b0;
            mem_read_d     = 1'b0;
            st_err_d       = 1'b0;
            if (issue_we_q) begin
               state_d = IDLE;
            end else begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = issue_ok_q ? mem_read_data : '0;
               rsp_err_d   = !issue_ok_q;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs; reset drops any in-flight response
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q           <= IDLE;
         issue_we_q        <= 1'b0;
         issue_ok_q        <= 1'b0;
         mem_access_addr_q <= '0;
         mem_write_data_q  <= '0;
         mem_write_en_q    <= 1'b0;
         mem_read_q        <= 1'b0;
         st_err_q          <= 1'b0;
         rsp_valid_q       <= 1'b0;
         rsp_rdata_q       <= '0;
         rsp_err_q         <= 1'b0;
      end else begin
         state_q           <= state_d;
         issue_we_q        <= issue_we_d;
         issue_ok_q        <= issue_ok_d;
         mem_access_addr_q <= mem_access_addr_d;
         mem_write_data_q  <= mem_write_data_d;
         mem_write_en_q    <= mem_write_en_d;
         mem_read_q        <= mem_read_d;
         st_err_q          <= st_err_d;
         rsp_valid_q       <= rsp_valid_d;
         rsp_rdata_q       <= rsp_rdata_d;
         rsp_err_q         <= rsp_err_d;
      end
   end

   assign req_ready       = !fifo_full;
   assign busy            = (fifo_count != '0) | (state_q != IDLE);
   assign mem_access_addr = mem_access_addr_q;
   assign mem_write_data  = mem_write_data_q;
   assign mem_write_en    = mem_write_en_q;
   assign mem_read        = mem_read_q;
   assign st_err          = st_err_q;
   assign rsp_valid       = rsp_valid_q;
   assign rsp_rdata       = rsp_rdata_q;
   assign rsp_err         = rsp_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: a behavioural memory, a request-level
// reference model and directed plus random traffic.
module tb_mem_access_unit;

   localparam int ROW   = 8;
   localparam int DEPTH = 2;

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
   } reqT;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [15:0] req_addr = '0;
   logic [15:0] req_wdata = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [15:0] rsp_rdata;
   logic        rsp_err;
   logic        st_err;
   logic        busy;
   logic [15:0] mem_access_addr;
   logic [15:0] mem_write_data;
   logic        mem_write_en;
   logic        mem_read;
   logic [15:0] mem_read_data;

   logic [15:0] envMem [ROW] = '{default: 16'h0};
   logic [15:0] refMem [ROW] = '{default: 16'h0};
   reqT         pend [$];

   int testsRun    = 0;
   int testsFailed = 0;
   int writesSeen  = 0;
   int readsSeen   = 0;
   int stErrSeen   = 0;
   bit randomRsp   = 1'b0;

   logic        holdPrev = 1'b0;
   logic [15:0] prevData = '0;
   logic        prevErr  = 1'b0;

   mem_access_unit #(.DEPTH(DEPTH), .ROW_D(ROW), .AW(16), .DW(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_we         (req_we),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .rsp_valid      (rsp_valid),
      .rsp_ready      (rsp_ready),
      .rsp_rdata      (rsp_rdata),
      .rsp_err        (rsp_err),
      .st_err         (st_err),
      .busy           (busy),
      .mem_access_addr(mem_access_addr),
      .mem_write_data (mem_write_data),
      .mem_write_en   (mem_write_en),
      .mem_read       (mem_read),
      .mem_read_data  (mem_read_data)
   );

   always #5 clk = ~clk;

   // Single-port data memory: combinational read, write on the clock edge
   assign mem_read_data = (mem_access_addr < 16'(ROW)) ? envMem[mem_access_addr[2:0]] : 16'hDEAD;

   always @(posedge clk) begin
      if (mem_write_en && mem_access_addr < 16'(ROW))
         envMem[mem_access_addr[2:0]] <= mem_write_data;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Request-level reference: every accepted request is retired in order by
   // the memory event (write, store error, or load response) it must produce
   always @(negedge clk) begin
      if (rst) begin
         pend.delete();
         holdPrev = 1'b0;
      end else begin
         if (mem_write_en) begin
            writesSeen++;
            checkOutput("wr_is_store", 32'(pend.size() != 0 && pend[0].we && pend[0].addr < 16'(ROW)), 1);
            if (pend.size() != 0) begin
               checkOutput("wr_addr", mem_access_addr, pend[0].addr);
               checkOutput("wr_data", mem_write_data, pend[0].wdata);
               if (pend[0].addr < 16'(ROW)) refMem[pend[0].addr[2:0]] = pend[0].wdata;
               void'(pend.pop_front());
            end
         end
         if (st_err) begin
            stErrSeen++;
            checkOutput("sterr_is_bad_store", 32'(pend.size() != 0 && pend[0].we && pend[0].addr >= 16'(ROW)), 1);
            if (pend.size() != 0) void'(pend.pop_front());
         end
         if (mem_read) begin
            readsSeen++;
            checkOutput("rd_is_load", 32'(pend.size() != 0 && !pend[0].we && pend[0].addr < 16'(ROW)), 1);
            if (pend.size() != 0) checkOutput("rd_addr", mem_access_addr, pend[0].addr);
         end
         if (holdPrev) begin
            checkOutput("hold_valid", rsp_valid, 1);
            checkOutput("hold_rdata", rsp_rdata, prevData);
            checkOutput("hold_err", rsp_err, prevErr);
         end
         if (rsp_valid && rsp_ready) begin
            checkOutput("rsp_is_load", 32'(pend.size() != 0 && !pend[0].we), 1);
            if (pend.size() != 0) begin
               if (pend[0].addr < 16'(ROW)) begin
                  checkOutput("rsp_rdata", rsp_rdata, refMem[pend[0].addr[2:0]]);
                  checkOutput("rsp_err", rsp_err, 0);
               end else begin
                  checkOutput("rsp_rdata_err", rsp_rdata, 0);
                  checkOutput("rsp_err_set", rsp_err, 1);
               end
               void'(pend.pop_front());
            end
         end
         holdPrev = rsp_valid && !rsp_ready;
         prevData = rsp_rdata;
         prevErr  = rsp_err;
         if (req_valid && req_ready) pend.push_back('{req_we, req_addr, req_wdata});
      end
   end

   task automatic stepCycle();
      @(posedge clk);
      #1;
      if (randomRsp) rsp_ready = 1'($urandom_range(0, 1));
   endtask

   // Offers one request and returns one step after the accepting edge
   task automatic applyStimulus(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
      bit accepted = 1'b0;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      for (int i = 0; i < 60 && !accepted; i++) begin
         @(negedge clk);
         if (req_ready) accepted = 1'b1;
         stepCycle();
      end
      req_valid = 1'b0;
      checkOutput("req_accepted", 32'(accepted), 1);
   endtask

   task automatic waitIdle(input int maxCycles);
      for (int i = 0; i < maxCycles; i++) begin
         @(negedge clk);
         if (!busy) break;
         stepCycle();
      end
      checkOutput("drain_idle", busy, 0);
      stepCycle();
   endtask

   initial begin
      int nAcc;
      int wBefore;
      int rBefore;
      int sBefore;
      logic [15:0] loadAddrs [4];
      logic [15:0] ra;
      int r;

      // Reset and idle
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkOutput("rst_req_ready", req_ready, 1);
         checkOutput("rst_busy", busy, 0);
         checkOutput("rst_wr_en", mem_write_en, 0);
         checkOutput("rst_rd", mem_read, 0);
         checkOutput("rst_rsp_valid", rsp_valid, 0);
         if (i == 0) begin
            checkOutput("rst_rdata", rsp_rdata, 0);
            checkOutput("rst_err", {rsp_err, st_err}, 0);
            checkOutput("rst_addr", mem_access_addr, 0);
            checkOutput("rst_wdata", mem_write_data, 0);
         end
      end
      stepCycle();

      // Prefill the memory with random data
      rsp_ready = 1'b1;
      for (int a = 0; a < ROW; a++) applyStimulus(1'b1, 16'(a), 16'($urandom));
      waitIdle(20);

      // Store then load at address 3
      wBefore = writesSeen;
      applyStimulus(1'b1, 16'd3, 16'hA5A5);
      stepCycle();
      checkOutput("st_wr_en", mem_write_en, 1);
      checkOutput("st_addr", mem_access_addr, 3);
      checkOutput("st_data", mem_write_data, 16'hA5A5);
      stepCycle();
      checkOutput("st_wr_done", mem_write_en, 0);
      applyStimulus(1'b0, 16'd3, 16'h0);
      stepCycle();
      checkOutput("ld_rd", mem_read, 1);
      checkOutput("ld_addr", mem_access_addr, 3);
      stepCycle();
      checkOutput("ld_valid", rsp_valid, 1);
      checkOutput("ld_rdata", rsp_rdata, 16'hA5A5);
      checkOutput("ld_err", rsp_err, 0);
      waitIdle(10);
      checkOutput("st_one_write", writesSeen - wBefore, 1);

      // Fill the queue while responses are stalled
      rsp_ready = 1'b0;
      loadAddrs[0] = 16'd1; loadAddrs[1] = 16'd2; loadAddrs[2] = 16'd5; loadAddrs[3] = 16'd6;
      nAcc = 0;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = loadAddrs[0];
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (req_ready) nAcc++;
         stepCycle();
         req_addr = loadAddrs[nAcc % 4];
      end
      checkOutput("fill_count", nAcc, DEPTH + 1);
      checkOutput("fill_ready", req_ready, 0);
      checkOutput("fill_rsp_valid", rsp_valid, 1);
      checkOutput("fill_rdata", rsp_rdata, refMem[1]);
      repeat (3) stepCycle();
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      waitIdle(30);

      // Out-of-range store at ROW_D
      wBefore = writesSeen;
      sBefore = stErrSeen;
      applyStimulus(1'b1, 16'd8, 16'h1234);
      stepCycle();
      checkOutput("oor_st_err", st_err, 1);
      checkOutput("oor_st_wr", mem_write_en, 0);
      stepCycle();
      checkOutput("oor_st_pulse", st_err, 0);
      waitIdle(10);
      checkOutput("oor_st_nowr", writesSeen - wBefore, 0);
      checkOutput("oor_st_count", stErrSeen - sBefore, 1);

      // Out-of-range load with high address bits
      rBefore = readsSeen;
      applyStimulus(1'b0, 16'h0100, 16'h0);
      stepCycle();
      stepCycle();
      checkOutput("oor_ld_valid", rsp_valid, 1);
      checkOutput("oor_ld_err", rsp_err, 1);
      checkOutput("oor_ld_rdata", rsp_rdata, 0);
      waitIdle(10);
      checkOutput("oor_ld_noread", readsSeen - rBefore, 0);

      // Reset while a response waits and a store is queued
      rsp_ready = 1'b0;
      wBefore = writesSeen;
      applyStimulus(1'b0, 16'd2, 16'h0);
      applyStimulus(1'b1, 16'd4, 16'hBEEF);
      stepCycle();
      checkOutput("rr_pre_valid", rsp_valid, 1);
      rst = 1'b1;
      stepCycle();
      rst = 1'b0;
      checkOutput("rr_valid", rsp_valid, 0);
      checkOutput("rr_busy", busy, 0);
      checkOutput("rr_ready", req_ready, 1);
      repeat (6) stepCycle();
      checkOutput("rr_nowrite", writesSeen - wBefore, 0);
      rsp_ready = 1'b1;

      // Random traffic with random response back-pressure
      randomRsp = 1'b1;
      for (int n = 0; n < 60; n++) begin
         r = int'($urandom_range(0, 11));
         if (r < 9) ra = 16'($urandom_range(0, ROW - 1));
         else if (r == 9) ra = 16'($urandom_range(ROW, ROW + 3));
         else ra = 16'($urandom_range(ROW, 65535));
         applyStimulus(1'($urandom_range(0, 1)), ra, 16'($urandom));
         repeat ($urandom_range(0, 2)) stepCycle();
      end
      randomRsp = 1'b0;
      rsp_ready = 1'b1;
      waitIdle(100);
      checkOutput("pend_empty", pend.size(), 0);

      for (int a = 0; a < ROW; a++) checkOutput($sformatf("mem_%0d", a), envMem[a], refMem[a]);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
